// File: rtl/led_pwm_bank.sv
// Multi-channel LED driver: one free-running PWM counter feeds phase-staggered breathe/blink
// waveforms. Mode and rate registers are double-buffered and swap only at the period boundary.
module led_pwm_bank #(
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned PWM_BITS   = 13,
  parameter int unsigned RATE_BITS  = 8,
  parameter logic [1:0]  MODE_RESET = 2'b10
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 cfg_we,
  input  logic [5:0]           cfg_addr,
  input  logic [RATE_BITS-1:0] cfg_data,
  output logic [CHANNELS-1:0]  led,
  output logic                 period_start
);

  localparam int unsigned PhBits   = PWM_BITS + 1;
  localparam logic [5:0]  RateAddr = 6'd63;

  localparam logic [1:0] ModeOff     = 2'b00;
  localparam logic [1:0] ModeOn      = 2'b01;
  localparam logic [1:0] ModeBreathe = 2'b10;
  localparam logic [1:0] ModeBlink   = 2'b11;

  typedef logic [PhBits-1:0] ph_t;
  typedef ph_t [CHANNELS-1:0] ph_arr_t;

  // Channel i starts i/CHANNELS of the way around the breathing cycle.
  function automatic ph_arr_t ph_reset_values();
    ph_arr_t     vals;
    logic [63:0] num;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      num     = (64'(i) << PhBits) / 64'(CHANNELS);
      vals[i] = num[PhBits-1:0];
    end
    return vals;
  endfunction

  localparam ph_arr_t PhReset = ph_reset_values();

  logic [PWM_BITS-1:0]      cnt_q, cnt_d;
  logic [RATE_BITS-1:0]     pre_q, pre_d;
  logic [RATE_BITS-1:0]     rate_q, rate_d;
  logic [RATE_BITS-1:0]     rate_sh_q, rate_sh_d;
  logic [CHANNELS-1:0][1:0] mode_q, mode_d;
  logic [CHANNELS-1:0][1:0] mode_sh_q, mode_sh_d;
  ph_arr_t                  ph_q, ph_d;
  logic [CHANNELS-1:0]      led_q, led_d;
  logic                     ps_q, ps_d;
  logic                     boundary;
  logic                     step;
  logic                     rate_wr;

  always_comb begin
    boundary = (cnt_q == {PWM_BITS{1'b1}});
    // The comparison uses the rate that was active before this boundary.
    step     = boundary && (pre_q == rate_q);
    cnt_d    = cnt_q + 1'b1;
    pre_d    = pre_q;
    if (boundary) begin
      pre_d = step ? '0 : pre_q + 1'b1;
    end
    rate_wr   = cfg_we && (cfg_addr == RateAddr);
    rate_sh_d = rate_wr ? cfg_data : rate_sh_q;
    rate_d    = boundary ? rate_sh_d : rate_q;
    ps_d      = boundary;
  end

  always_comb begin
    logic [PWM_BITS-1:0] duty;
    duty      = '0;
    mode_sh_d = mode_sh_q;
    mode_d    = mode_q;
    ph_d      = ph_q;
    led_d     = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg_we && (cfg_addr == 6'(i))) begin
        mode_sh_d[i] = cfg_data[1:0];
      end
      // A write landing in the boundary cycle reaches the active copy at this same edge.
      if (boundary) begin
        mode_d[i] = mode_sh_d[i];
      end
      if (step) begin
        ph_d[i] = ph_q[i] + 1'b1;
      end
      duty = ph_d[i][PWM_BITS] ? ~ph_d[i][PWM_BITS-1:0] : ph_d[i][PWM_BITS-1:0];
      // Built from next-state values so the registered led lines up with cnt_q and
      // period_start: a new mode appears exactly at the first cycle of a period.
      unique case (mode_d[i])
        ModeOff:     led_d[i] = 1'b0;
        ModeOn:      led_d[i] = 1'b1;
        ModeBreathe: led_d[i] = (cnt_d < duty);
        ModeBlink:   led_d[i] = ph_d[i][PWM_BITS];
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q     <= '0;
      pre_q     <= '0;
      rate_q    <= '0;
      rate_sh_q <= '0;
      mode_q    <= {CHANNELS{MODE_RESET}};
      mode_sh_q <= {CHANNELS{MODE_RESET}};
      ph_q      <= PhReset;
      led_q     <= '0;
      ps_q      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      pre_q     <= pre_d;
      rate_q    <= rate_d;
      rate_sh_q <= rate_sh_d;
      mode_q    <= mode_d;
      mode_sh_q <= mode_sh_d;
      ph_q      <= ph_d;
      led_q     <= led_d;
      ps_q      <= ps_d;
    end
  end

  assign led          = led_q;
  assign period_start = ps_q;

endmodule
